// File: rtl/onehot_dispatch.sv
// Registered 3-to-8 one-hot dispatcher: accepts an index, drives one line for HOLD cycles, then a dead cycle.
// Optional cancel of the active drive is enabled by defining ONEHOT_DISPATCH_ABORT_EN.
module onehot_dispatch #(
   parameter int HOLD = 4
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       in_valid,
   output logic       in_ready,
   input  logic [2:0] idx,
   output logic [7:0] d,
   output logic       busy,
   output logic       done,
   output logic [2:0] last_idx
`ifdef ONEHOT_DISPATCH_ABORT_EN
   ,
   input  logic       abort,
   output logic       aborted
`endif
);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_DRIVE = 2'd1,
      S_GAP   = 2'd2
   } state_t;

   localparam logic [7:0] HOLD_M1 = 8'(HOLD - 1);

   state_t     r_state, w_state_next;
   logic [7:0] r_cnt, w_cnt_next;
   logic [7:0] r_d, w_d_next;
   logic       r_ready, w_ready_next;
   logic       r_busy, w_busy_next;
   logic       r_done, w_done_next;
   logic [2:0] r_last_idx, w_last_idx_next;
   logic       w_abort;
   logic       w_accept;
   logic [7:0] w_decode;

`ifdef ONEHOT_DISPATCH_ABORT_EN
   logic r_aborted, w_aborted_next;
   assign w_abort = abort;
   assign aborted = r_aborted;
`else
   assign w_abort = 1'b0;
`endif

   genvar gi;
   generate
      for (gi = 0; gi < 8; gi++) begin : g_decode
         assign w_decode[gi] = (idx == 3'(gi));
      end
   endgenerate

   assign w_accept = (r_state == S_IDLE) && in_valid;

   // State register: every output is a flop so downstream sees glitch-free strobes.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state    <= S_IDLE;
         r_cnt      <= 8'd0;
         r_d        <= 8'h00;
         r_ready    <= 1'b1;
         r_busy     <= 1'b0;
         r_done     <= 1'b0;
         r_last_idx <= 3'b000;
`ifdef ONEHOT_DISPATCH_ABORT_EN
         r_aborted  <= 1'b0;
`endif
      end else begin
         r_state    <= w_state_next;
         r_cnt      <= w_cnt_next;
         r_d        <= w_d_next;
         r_ready    <= w_ready_next;
         r_busy     <= w_busy_next;
         r_done     <= w_done_next;
         r_last_idx <= w_last_idx_next;
`ifdef ONEHOT_DISPATCH_ABORT_EN
         r_aborted  <= w_aborted_next;
`endif
      end
   end

   always_comb begin
      w_state_next = r_state;
      w_cnt_next   = r_cnt;
      case (r_state)
         S_IDLE: begin
            if (in_valid) begin
               w_state_next = S_DRIVE;
               w_cnt_next   = HOLD_M1;
            end
         end
         S_DRIVE: begin
            // A cancel on the final cycle still wins over normal completion.
            if (w_abort || (r_cnt == 8'd0)) begin
               w_state_next = S_GAP;
               w_cnt_next   = 8'd0;
            end else begin
               w_cnt_next = r_cnt - 8'd1;
            end
         end
         S_GAP: begin
            w_state_next = S_IDLE;
         end
         default: begin
            w_state_next = S_IDLE;
            w_cnt_next   = 8'd0;
         end
      endcase
   end

   always_comb begin
      w_d_next        = 8'h00;
      w_ready_next    = (w_state_next == S_IDLE);
      w_busy_next     = (w_state_next != S_IDLE);
      w_done_next     = (r_state == S_DRIVE) && (w_state_next == S_GAP) && !w_abort;
      w_last_idx_next = r_last_idx;
      if (w_accept) begin
         w_d_next        = w_decode;
         w_last_idx_next = idx;
      end else if ((r_state == S_DRIVE) && (w_state_next == S_DRIVE)) begin
         w_d_next = r_d;
      end
`ifdef ONEHOT_DISPATCH_ABORT_EN
      w_aborted_next = (r_state == S_DRIVE) && w_abort;
`endif
   end

   assign d        = r_d;
   assign in_ready = r_ready;
   assign busy     = r_busy;
   assign done     = r_done;
   assign last_idx = r_last_idx;

endmodule

// File: tb/tb_onehot_dispatch.sv
// Directed self-checking bench for onehot_dispatch: HOLD=4 and HOLD=1 instances side by side.
// Abort scenarios run only when ONEHOT_DISPATCH_ABORT_EN is defined.
module tb_onehot_dispatch;

   logic       clk = 1'b0;
   logic       rst;
   logic       valid4, ready4, busy4, done4;
   logic [2:0] idx4, last4;
   logic [7:0] d4;
   logic       valid1, ready1, busy1, done1;
   logic [2:0] idx1, last1;
   logic [7:0] d1;
`ifdef ONEHOT_DISPATCH_ABORT_EN
   logic       abort4, aborted4, abort1, aborted1;
`endif

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   onehot_dispatch #(.HOLD(4)) u_dut4 (
      .clk(clk), .rst(rst), .in_valid(valid4), .in_ready(ready4), .idx(idx4),
      .d(d4), .busy(busy4), .done(done4), .last_idx(last4)
`ifdef ONEHOT_DISPATCH_ABORT_EN
      , .abort(abort4), .aborted(aborted4)
`endif
   );

   onehot_dispatch #(.HOLD(1)) u_dut1 (
      .clk(clk), .rst(rst), .in_valid(valid1), .in_ready(ready1), .idx(idx1),
      .d(d1), .busy(busy1), .done(done1), .last_idx(last1)
`ifdef ONEHOT_DISPATCH_ABORT_EN
      , .abort(abort1), .aborted(aborted1)
`endif
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      @(negedge clk);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [7:0] exp_b2b [7];
      logic [7:0] exp_d1  [4];
      logic       exp_dn1 [4];
      logic       exp_rd1 [4];
      int         n;

      exp_b2b = '{8'h80, 8'h80, 8'h80, 8'h80, 8'h00, 8'h00, 8'h01};
      exp_d1  = '{8'h08, 8'h00, 8'h00, 8'h08};
      exp_dn1 = '{1'b0, 1'b1, 1'b0, 1'b0};
      exp_rd1 = '{1'b0, 1'b0, 1'b1, 1'b0};

      rst = 1'b1; valid4 = 1'b0; idx4 = 3'd0; valid1 = 1'b0; idx1 = 3'd0;
`ifdef ONEHOT_DISPATCH_ABORT_EN
      abort4 = 1'b0; abort1 = 1'b0;
`endif
      repeat (3) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      step();
      $display("txn reset: d=%h ready=%b busy=%b done=%b last=%0d", d4, ready4, busy4, done4, last4);
      check("rst_d", d4, 8'h00);
      check("rst_ready", ready4, 1);
      check("rst_busy", busy4, 0);
      check("rst_done", done4, 0);
      check("rst_last", last4, 0);

      // Single command idx=5
      valid4 = 1'b1; idx4 = 3'd5;
      step();
      valid4 = 1'b0;
      $display("txn accept idx=5: d=%h last=%0d", d4, last4);
      check("a5_d", d4, 8'h20);
      check("a5_ready", ready4, 0);
      check("a5_busy", busy4, 1);
      check("a5_last", last4, 5);
      for (int k = 0; k < 3; k++) begin
         step();
         check("a5_hold_d", d4, 8'h20);
         check("a5_hold_done", done4, 0);
      end
      step();
      check("a5_end_d", d4, 8'h00);
      check("a5_end_done", done4, 1);
      check("a5_end_ready", ready4, 0);
      step();
      check("a5_idle_ready", ready4, 1);
      check("a5_idle_done", done4, 0);
      check("a5_idle_busy", busy4, 0);

      // Back-to-back with in_valid held; idx change while busy is ignored
      valid4 = 1'b1; idx4 = 3'd7;
      for (int k = 0; k < 7; k++) begin
         step();
         $display("txn b2b cycle %0d: d=%h", k, d4);
         check("b2b_d", d4, exp_b2b[k]);
         if (k == 0) idx4 = 3'd0;
      end
      valid4 = 1'b0;
      check("b2b_last", last4, 0);
      n = 0;
      while (!ready4 && n < 20) begin step(); n++; end
      check("b2b_idle_timeout", n < 20, 1);

      // HOLD=1 instance, idx=3 with in_valid held
      valid1 = 1'b1; idx1 = 3'd3;
      for (int k = 0; k < 4; k++) begin
         step();
         $display("txn hold1 cycle %0d: d=%h done=%b ready=%b", k, d1, done1, ready1);
         check("h1_d", d1, exp_d1[k]);
         check("h1_done", done1, exp_dn1[k]);
         check("h1_ready", ready1, exp_rd1[k]);
      end
      valid1 = 1'b0;
      n = 0;
      while (!ready1 && n < 20) begin step(); n++; end
      check("h1_idle_timeout", n < 20, 1);

      // Reset during the second DRIVE cycle
      valid4 = 1'b1; idx4 = 3'd6;
      step();
      valid4 = 1'b0;
      check("r6_d1", d4, 8'h40);
      step();
      check("r6_d2", d4, 8'h40);
      rst = 1'b1;
      step();
      rst = 1'b0;
      $display("txn reset mid-drive: d=%h ready=%b last=%0d", d4, ready4, last4);
      check("r6_d", d4, 8'h00);
      check("r6_ready", ready4, 1);
      check("r6_busy", busy4, 0);
      check("r6_last", last4, 0);
      for (int k = 0; k < 6; k++) begin
         step();
         check("r6_no_done", done4, 0);
         check("r6_d_zero", d4, 8'h00);
      end

`ifdef ONEHOT_DISPATCH_ABORT_EN
      abort4 = 1'b1;
      step();
      abort4 = 1'b0;
      check("ab_idle_aborted", aborted4, 0);
      check("ab_idle_busy", busy4, 0);

      // Abort on the second DRIVE cycle
      valid4 = 1'b1; idx4 = 3'd2;
      step();
      valid4 = 1'b0;
      check("ab1_d1", d4, 8'h04);
      step();
      check("ab1_d2", d4, 8'h04);
      abort4 = 1'b1;
      step();
      abort4 = 1'b0;
      $display("txn abort mid: d=%h aborted=%b done=%b", d4, aborted4, done4);
      check("ab1_d", d4, 8'h00);
      check("ab1_aborted", aborted4, 1);
      check("ab1_done", done4, 0);
      check("ab1_busy", busy4, 1);
      step();
      check("ab1_aborted_clr", aborted4, 0);
      check("ab1_done_clr", done4, 0);
      check("ab1_ready", ready4, 1);

      // Abort on the final DRIVE cycle wins over done
      valid4 = 1'b1; idx4 = 3'd2;
      step();
      valid4 = 1'b0;
      step(); step(); step();
      check("ab2_last_d", d4, 8'h04);
      abort4 = 1'b1;
      step();
      abort4 = 1'b0;
      $display("txn abort final: d=%h aborted=%b done=%b", d4, aborted4, done4);
      check("ab2_aborted", aborted4, 1);
      check("ab2_done", done4, 0);
      check("ab2_d", d4, 8'h00);
      step();
      check("ab2_aborted_clr", aborted4, 0);
      check("ab2_done_clr", done4, 0);
      check("ab2_ready", ready4, 1);
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
